// File: rtl/bp_update_sched_if.sv
// bp_update_sched_if: branch-resolution inputs and predictor-update outputs of the update scheduler
interface bp_update_sched_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
);
  logic                       res_valid_a;
  logic [31:0]                res_pc_a;
  logic                       res_taken_a;
  logic                       res_ready_a;
  logic                       res_valid_b;
  logic [31:0]                res_pc_b;
  logic                       res_taken_b;
  logic                       res_ready_b;
  logic                       hold;
  logic                       flush;
  logic                       upd_wr_en;
  logic [31:0]                upd_pc;
  logic                       upd_taken;
  logic [$clog2(DEPTH):0]     occupancy;
  logic [CNT_W-1:0]           upd_count;

  modport master (
    output res_valid_a, res_pc_a, res_taken_a, res_valid_b, res_pc_b, res_taken_b, hold, flush,
    input  res_ready_a, res_ready_b, upd_wr_en, upd_pc, upd_taken, occupancy, upd_count
  );

  modport slave (
    input  res_valid_a, res_pc_a, res_taken_a, res_valid_b, res_pc_b, res_taken_b, hold, flush,
    output res_ready_a, res_ready_b, upd_wr_en, upd_pc, upd_taken, occupancy, upd_count
  );
endinterface

// File: rtl/bp_update_sched.sv
// bp_update_sched: in-order FIFO serialising two resolved-branch ports onto one predictor update port
module bp_update_sched #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  bp_update_sched_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [31:0]      pc_mem [DEPTH];
  logic [DEPTH-1:0] tk_mem;
  logic [PW-1:0]    wr_ptr, rd_ptr, b_ptr;
  logic [OW-1:0]    occ, free;
  logic [CNT_W-1:0] cnt;
  logic             rdy_a, rdy_b, acc_a, acc_b, deq, empty;

  // Space is judged from registered occupancy only, so a same-cycle dequeue never frees a slot;
  // B needs a second slot whenever A is presenting so it can never overtake the older branch.
  always_comb begin
    free  = OW'(DEPTH) - occ;
    empty = occ == '0;
    rdy_a = !bus.flush && free >= OW'(1);
    rdy_b = !bus.flush && (bus.res_valid_a ? free >= OW'(2) : free >= OW'(1));
    acc_a = bus.res_valid_a && rdy_a;
    acc_b = bus.res_valid_b && rdy_b;
    b_ptr = wr_ptr + PW'(acc_a);
    deq   = !empty && !bus.hold && !bus.flush;
  end

  assign bus.res_ready_a = rdy_a;
  assign bus.res_ready_b = rdy_b;
  assign bus.upd_wr_en   = deq;
  assign bus.upd_pc      = empty ? '0 : pc_mem[rd_ptr];
  assign bus.upd_taken   = !empty && tk_mem[rd_ptr];
  assign bus.occupancy   = occ;
  assign bus.upd_count   = cnt;

  // Pointer, occupancy and issued-count bookkeeping; flush empties the queue but keeps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      cnt    <= '0;
    end else begin
      if (deq) cnt <= cnt + CNT_W'(1);
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(acc_a) + PW'(acc_b);
        rd_ptr <= rd_ptr + PW'(deq);
        occ    <= occ + OW'(acc_a) + OW'(acc_b) - OW'(deq);
      end
    end
  end

  // Entry storage: A lands at wr_ptr, B right behind whatever A took this cycle.
  always_ff @(posedge clk) begin
    if (acc_a) begin
      pc_mem[wr_ptr] <= bus.res_pc_a;
      tk_mem[wr_ptr] <= bus.res_taken_a;
    end
    if (acc_b) begin
      pc_mem[b_ptr] <= bus.res_pc_b;
      tk_mem[b_ptr] <= bus.res_taken_b;
    end
  end
endmodule

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: directed scoreboard bench for bp_update_sched
module tb_bp_update_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  logic [32:0] sb [$];

  bp_update_sched_if #(.DEPTH(4), .CNT_W(32)) ifc ();
  bp_update_sched #(.DEPTH(4), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.res_valid_a = 1'b0;
    ifc.res_valid_b = 1'b0;
    ifc.res_pc_a = '0;
    ifc.res_pc_b = '0;
    ifc.res_taken_a = 1'b0;
    ifc.res_taken_b = 1'b0;
  endtask

  task automatic drive_a(input logic [31:0] pc, input logic t);
    ifc.res_valid_a = 1'b1;
    ifc.res_pc_a = pc;
    ifc.res_taken_a = t;
  endtask

  task automatic drive_b(input logic [31:0] pc, input logic t);
    ifc.res_valid_b = 1'b1;
    ifc.res_pc_b = pc;
    ifc.res_taken_b = t;
  endtask

  // Every issued update must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && ifc.upd_wr_en === 1'b1) begin
      logic [32:0] e;
      check("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("upd_pc", ifc.upd_pc, e[31:0]);
        check("upd_taken", 32'(ifc.upd_taken), 32'(e[32]));
      end
    end
  end

  initial begin
    idle();
    ifc.hold = 1'b0;
    ifc.flush = 1'b0;
    #1;
    check("rst_wr_en", 32'(ifc.upd_wr_en), 32'd0);
    check("rst_occ", 32'(ifc.occupancy), 32'd0);
    check("rst_cnt", ifc.upd_count, 32'd0);
    check("rst_pc", ifc.upd_pc, 32'd0);
    check("rst_rdy_a", 32'(ifc.res_ready_a), 32'd1);
    check("rst_rdy_b", 32'(ifc.res_ready_b), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    drive_a(32'h100, 1'b1);
    #1 check("a_rdy", 32'(ifc.res_ready_a), 32'd1);
    sb.push_back({1'b1, 32'h100});
    tick();
    idle();
    #1 check("a_wr_en", 32'(ifc.upd_wr_en), 32'd1);
    check("a_pc", ifc.upd_pc, 32'h100);
    check("a_taken", 32'(ifc.upd_taken), 32'd1);
    tick();
    check("a_idle", 32'(ifc.upd_wr_en), 32'd0);
    check("a_cnt", ifc.upd_count, 32'd1);

    drive_a(32'h200, 1'b1);
    drive_b(32'h204, 1'b0);
    #1 check("pair_rdy_b", 32'(ifc.res_ready_b), 32'd1);
    sb.push_back({1'b1, 32'h200});
    sb.push_back({1'b0, 32'h204});
    tick();
    idle();
    #1 check("pair_pc0", ifc.upd_pc, 32'h200);
    check("pair_tk0", 32'(ifc.upd_taken), 32'd1);
    tick();
    check("pair_pc1", ifc.upd_pc, 32'h204);
    check("pair_tk1", 32'(ifc.upd_taken), 32'd0);
    tick();
    check("pair_idle", 32'(ifc.upd_wr_en), 32'd0);
    check("pair_cnt", ifc.upd_count, 32'd3);

    ifc.hold = 1'b1;
    drive_a(32'h300, 1'b1);
    drive_b(32'h304, 1'b0);
    sb.push_back({1'b1, 32'h300});
    sb.push_back({1'b0, 32'h304});
    tick();
    idle();
    drive_a(32'h308, 1'b1);
    sb.push_back({1'b1, 32'h308});
    tick();
    idle();
    #1 check("cap_occ3", 32'(ifc.occupancy), 32'd3);
    check("cap_hold_wr", 32'(ifc.upd_wr_en), 32'd0);
    drive_a(32'h30c, 1'b0);
    drive_b(32'h310, 1'b1);
    #1 check("cap_rdy_a", 32'(ifc.res_ready_a), 32'd1);
    check("cap_rdy_b", 32'(ifc.res_ready_b), 32'd0);
    sb.push_back({1'b0, 32'h30c});
    tick();
    idle();
    #1 check("cap_occ4", 32'(ifc.occupancy), 32'd4);
    ifc.hold = 1'b0;
    drive_a(32'h3ff, 1'b1);
    #1 check("full_deq_wr", 32'(ifc.upd_wr_en), 32'd1);
    check("full_deq_rdy", 32'(ifc.res_ready_a), 32'd0);
    tick();
    idle();
    repeat (4) tick();
    check("cap_drained", 32'(ifc.occupancy), 32'd0);
    check("cap_cnt", ifc.upd_count, 32'd7);

    ifc.hold = 1'b1;
    drive_a(32'h400, 1'b1);
    drive_b(32'h404, 1'b1);
    sb.push_back({1'b1, 32'h400});
    sb.push_back({1'b1, 32'h404});
    tick();
    idle();
    drive_a(32'h408, 1'b0);
    sb.push_back({1'b0, 32'h408});
    tick();
    idle();
    #1 check("fl_occ3", 32'(ifc.occupancy), 32'd3);
    ifc.hold = 1'b0;
    ifc.flush = 1'b1;
    drive_a(32'h40c, 1'b1);
    #1 check("fl_rdy_a", 32'(ifc.res_ready_a), 32'd0);
    check("fl_wr_en", 32'(ifc.upd_wr_en), 32'd0);
    tick();
    ifc.flush = 1'b0;
    idle();
    sb.delete();
    #1 check("fl_occ0", 32'(ifc.occupancy), 32'd0);
    check("fl_cnt", ifc.upd_count, 32'd7);
    check("fl_wr_after", 32'(ifc.upd_wr_en), 32'd0);

    for (int i = 0; i < 10; i++) begin
      logic [31:0] pc;
      logic t;
      pc = 32'h500 + 32'(4 * i);
      t = ((i & 1) != 0) ^ ((i & 2) != 0);
      ifc.hold = (i % 4) == 1;
      if (i % 2 == 0) drive_a(pc, t);
      else drive_b(pc, t);
      #1 check("wrap_rdy", 32'(i % 2 == 0 ? ifc.res_ready_a : ifc.res_ready_b), 32'd1);
      sb.push_back({t, pc});
      tick();
      idle();
    end
    ifc.hold = 1'b0;
    repeat (10) tick();
    check("wrap_occ", 32'(ifc.occupancy), 32'd0);
    check("wrap_cnt", ifc.upd_count, 32'd17);
    check("wrap_sb_empty", 32'(sb.size()), 32'd0);

    ifc.hold = 1'b1;
    drive_a(32'h600, 1'b1);
    tick();
    drive_a(32'h604, 1'b0);
    tick();
    idle();
    #2 rst_n = 1'b0;
    #1 check("arst_occ", 32'(ifc.occupancy), 32'd0);
    check("arst_cnt", ifc.upd_count, 32'd0);
    check("arst_pc", ifc.upd_pc, 32'd0);
    check("arst_wr_en", 32'(ifc.upd_wr_en), 32'd0);
    ifc.hold = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_after_occ", 32'(ifc.occupancy), 32'd0);
    check("arst_after_wr", 32'(ifc.upd_wr_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
